// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register for the MIPS core.
// Holds up to two beats (head + skid) so in_ready can come straight from a flop.
// Also provides a synchronous flush and a saturating stall-cycle counter.
module pipe_stage_elastic #(
  parameter int D_W    = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 12,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D_W-1:0]    in_d1,
  input  logic [D_W-1:0]    in_d2,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D_W-1:0]    out_d1,
  output logic [D_W-1:0]    out_d2,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam int P_W = 2*D_W + 3*REG_W + CTRL_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_reg, state_next;
  logic              in_ready_reg;
  logic [P_W-1:0]    h_reg, s_reg;
  logic [P_W-1:0]    in_payload;
  logic [STAT_W-1:0] stall_reg;
  logic [CTRL_W-1:0] h_ctrl;
  logic              accept, emit;
  logic              load_h_in, load_h_skid, load_s;

  assign in_payload = {in_d1, in_d2, in_rs, in_rt, in_rd, in_ctrl};
  assign accept     = in_valid & in_ready_reg;
  assign out_valid  = (state_reg != EMPTY);
  assign emit       = out_valid & out_ready;

  assign in_ready  = in_ready_reg;
  assign stall_cnt = stall_reg;
  assign {out_d1, out_d2, out_rs, out_rt, out_rd, h_ctrl} = h_reg;
  // An empty stage must look like a NOP downstream.
  assign out_ctrl = out_valid ? h_ctrl : '0;

  // Next-state decode and entry load enables; flush overrides everything.
  always_comb begin
    state_next  = state_reg;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    unique case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_h_in  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          load_s     = 1'b1;
          state_next = TWO;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          load_h_skid = 1'b1;
          state_next  = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next  = EMPTY;
      load_h_in   = 1'b0;
      load_h_skid = 1'b0;
      load_s      = 1'b0;
    end
  end

  // State register; in_ready is the registered decode of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  // Head/skid payload storage; flush clears both so no stale data lingers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_reg <= '0;
      s_reg <= '0;
    end else if (flush) begin
      h_reg <= '0;
      s_reg <= '0;
    end else begin
      if (load_h_in) begin
        h_reg <= in_payload;
      end else if (load_h_skid) begin
        h_reg <= s_reg;
      end
      if (load_s) begin
        s_reg <= in_payload;
      end
    end
  end

  // Saturating count of cycles where the head beat is blocked downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready && (stall_reg != {STAT_W{1'b1}})) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: scoreboard of accepted beats,
// directed reset/stream/skid/flush/counter cases, then a random valid/ready run.
module tb_pipe_stage_elastic;

  localparam int STAT_W   = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
  localparam int N_RAND   = 10000;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d1, in_d2;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [11:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d1, out_d2;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [11:0] out_ctrl;
  logic [STAT_W-1:0] stall_cnt;

  pipe_stage_elastic #(.D_W(32), .REG_W(5), .CTRL_W(12), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d1(in_d1), .in_d2(in_d2), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d1(out_d1), .out_d2(out_d2), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  int    n_total = 0;
  int    n_bad   = 0;
  beat_t sb[$];
  int    model_stall = 0;
  logic  held_valid = 1'b0;
  beat_t held;
  int    n_acc = 0;
  int    n_emit = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int n);
    beat_t b;
    b.d1   = n;
    b.d2   = $urandom;
    b.rs   = 5'($urandom);
    b.rt   = 5'($urandom);
    b.rd   = 5'($urandom);
    b.ctrl = 12'($urandom);
    return b;
  endfunction

  function automatic beat_t cur_out();
    beat_t b;
    b.d1 = out_d1; b.d2 = out_d2; b.rs = out_rs; b.rt = out_rt; b.rd = out_rd;
    b.ctrl = out_ctrl;
    return b;
  endfunction

  // One clock cycle: called just after a falling edge, drives inputs,
  // scores the handshake that the next rising edge will perform, and
  // returns at the following falling edge.
  task automatic cycle(input logic v, input beat_t b, input logic r, input logic f);
    logic acc, emi, stalled;
    in_valid = v;
    {in_d1, in_d2, in_rs, in_rt, in_rd, in_ctrl} = b;
    out_ready = r;
    flush = f;
    #1;
    acc = in_valid & in_ready;
    emi = out_valid & out_ready;
    stalled = out_valid & ~out_ready;
    check("stall_cnt", 96'(stall_cnt), 96'(model_stall));
    if (!out_valid) check("nop_ctrl", 96'(out_ctrl), 96'(0));
    if (held_valid) check("hold_stable", {out_valid, cur_out()}, {1'b1, held});
    if (emi) begin
      check("sb_nonempty", 96'(sb.size() > 0), 96'(1));
      if (sb.size() > 0) check("beat", 96'(cur_out()), 96'(sb.pop_front()));
      n_emit++;
    end
    held_valid = stalled & ~f;
    held = cur_out();
    if (stalled && model_stall < STAT_MAX) model_stall++;
    if (f) sb.delete();
    else if (acc) begin
      sb.push_back(b);
      n_acc++;
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, '0, r, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    model_stall = 0;
    held_valid = 1'b0;
  endtask

  initial begin
    beat_t bA, bB, bC;
    int cyc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_d1, in_d2, in_rs, in_rt, in_rd, in_ctrl} = '0;
    #1;
    // Reset state
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(1));
    check("rst_stall", 96'(stall_cnt), 96'(0));
    check("rst_payload", 96'(cur_out()), 96'(0));
    do_reset();

    // Counter saturation: one beat held, downstream blocked for 20 cycles
    cycle(1'b1, mk(32'h55), 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) idle(1'b0);
    check("stall_14", 96'(stall_cnt), 96'(14));
    for (int i = 0; i < 6; i++) idle(1'b0);
    check("stall_sat", 96'(stall_cnt), 96'(STAT_MAX));
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset with two beats held
    cycle(1'b1, mk(32'h1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h2), 1'b0, 1'b0);
    check("pre_rst_in_ready", 96'(in_ready), 96'(0));
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 96'(out_valid), 96'(0));
    check("async_rst_ready", 96'(in_ready), 96'(1));
    check("async_rst_stall", 96'(stall_cnt), 96'(0));
    @(negedge clock);
    reset = 1'b0;
    sb.delete(); model_stall = 0; held_valid = 1'b0;

    // Streaming: each beat is visible one cycle after acceptance
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, mk(i), 1'b1, 1'b0);
      check("stream_valid", 96'(out_valid), 96'(1));
      check("stream_d1", 96'(out_d1), 96'(i));
    end
    idle(1'b1);
    check("stream_drained", 96'(out_valid), 96'(0));

    // Skid: two beats absorbed while downstream is blocked
    bA = mk(32'hA); bB = mk(32'hB);
    cycle(1'b1, bA, 1'b0, 1'b0);
    check("skid_a_head", 96'(out_d1), 96'(32'hA));
    check("skid_ready1", 96'(in_ready), 96'(1));
    cycle(1'b1, bB, 1'b0, 1'b0);
    check("skid_ready0", 96'(in_ready), 96'(0));
    cycle(1'b1, mk(32'hEE), 1'b0, 1'b0);
    idle(1'b1);
    check("skid_b_head", 96'(out_d1), 96'(32'hB));
    check("skid_ready_back", 96'(in_ready), 96'(1));
    idle(1'b1);
    check("skid_empty", 96'(out_valid), 96'(0));

    // Flush in TWO with a simultaneous incoming beat
    cycle(1'b1, mk(32'h1A), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h1B), 1'b0, 1'b0);
    bC = mk(32'hC);
    cycle(1'b1, bC, 1'b0, 1'b1);
    check("flush_valid", 96'(out_valid), 96'(0));
    check("flush_ctrl", 96'(out_ctrl), 96'(0));
    check("flush_ready", 96'(in_ready), 96'(1));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random valid/ready traffic against the scoreboard
    cyc = 0;
    n_acc = 0; n_emit = 0;
    while (n_acc < N_RAND && cyc < 60000) begin
      cycle($urandom_range(0, 99) < 70, mk(n_acc + 100),
            $urandom_range(0, 99) < 65, 1'b0);
      cyc++;
    end
    check("rand_budget", 96'(n_acc >= N_RAND), 96'(1));
    cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      idle(1'b1);
      cyc++;
    end
    check("rand_drained", 96'(sb.size()), 96'(0));
    check("rand_count", 96'(n_emit), 96'(n_acc));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
